// File: rtl/axi4_copy_master.sv
// Single-beat AXI4 copy engine: reads one word from src, writes it to dst, repeats len_words times.
// Keeps at most one transaction in flight and accumulates an XOR checksum of every word moved.
module axi4_copy_master #(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len_words,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] words_done,
   output logic [31:0]      checksum,
   output logic             awvalid,
   output logic [31:0]      awaddr,
   input  logic             awready,
   output logic             wvalid,
   output logic [31:0]      wdata,
   output logic [3:0]       wstrb,
   input  logic             wready,
   input  logic             bvalid,
   output logic             bready,
   output logic             arvalid,
   output logic [31:0]      araddr,
   input  logic             arready,
   input  logic             rvalid,
   input  logic [31:0]      rdata,
   output logic             rready
);

   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      src_q, src_d;
   logic [31:0]      dst_q, dst_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] words_done_q, words_done_d;
   logic [31:0]      checksum_q, checksum_d;
   logic [31:0]      data_q, data_d;
   logic             aw_done_q, aw_done_d;
   logic             w_done_q, w_done_d;
   logic             aw_hs, w_hs;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         len_q        <= '0;
         words_done_q <= '0;
         checksum_q   <= '0;
         data_q       <= '0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         len_q        <= len_d;
         words_done_q <= words_done_d;
         checksum_q   <= checksum_d;
         data_q       <= data_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
      end
   end

   // AW and W each retire on their own handshake; WR ends once both have retired.
   assign aw_hs = (state_q == WR) && !aw_done_q && awready;
   assign w_hs  = (state_q == WR) && !w_done_q && wready;

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      dst_d        = dst_q;
      len_d        = len_q;
      words_done_d = words_done_q;
      checksum_d   = checksum_q;
      data_d       = data_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               words_done_d = '0;
               checksum_d   = '0;
               if (len_words != '0) begin
                  src_d   = {src_addr[31:2], 2'b00};
                  dst_d   = {dst_addr[31:2], 2'b00};
                  len_d   = len_words;
                  state_d = RD_ADDR;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RD_ADDR: begin
            if (arready) state_d = RD_DATA;
         end
         RD_DATA: begin
            if (rvalid) begin
               data_d     = rdata;
               checksum_d = checksum_q ^ rdata;
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
               state_d    = WR;
            end
         end
         WR: begin
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
         end
         WR_RESP: begin
            if (bvalid) begin
               words_done_d = words_done_q + LEN_W'(1);
               src_d        = src_q + 32'd4;
               dst_d        = dst_q + 32'd4;
               state_d      = ((words_done_q + LEN_W'(1)) == len_q) ? DONE : RD_ADDR;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign words_done = words_done_q;
   assign checksum   = checksum_q;
   assign arvalid    = (state_q == RD_ADDR);
   assign araddr     = src_q;
   assign rready     = (state_q == RD_DATA);
   assign awvalid    = (state_q == WR) && !aw_done_q;
   assign awaddr     = dst_q;
   assign wvalid     = (state_q == WR) && !w_done_q;
   assign wdata      = data_q;
   assign wstrb      = (state_q == WR) ? 4'hF : 4'h0;
   assign bready     = (state_q == WR_RESP);

endmodule

// File: tb/tb_axi4_copy_master.sv
// Scoreboard bench for axi4_copy_master: directed copies against a behavioural AXI slave with
// programmable per-channel delays; a negedge monitor pops expected beats and done results.
module tb_axi4_copy_master;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [31:0] src_addr, dst_addr;
   logic [15:0] len_words;
   logic        busy, done;
   logic [15:0] words_done;
   logic [31:0] checksum;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic        arvalid, arready, rvalid, rready;

   axi4_copy_master #(.LEN_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .len_words(len_words), .busy(busy), .done(done), .words_done(words_done),
      .checksum(checksum), .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
      .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready), .bvalid(bvalid),
      .bready(bready), .arvalid(arvalid), .araddr(araddr), .arready(arready),
      .rvalid(rvalid), .rdata(rdata), .rready(rready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] wd;
      logic [31:0] cs;
   } done_t;

   logic [31:0] exp_ar[$];
   logic [31:0] exp_aw[$];
   logic [31:0] exp_w[$];
   done_t       exp_done[$];

   int n_pass = 0;
   int n_tot  = 0;
   int done_cnt = 0;
   int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
   bit w_after_aw = 1'b1;
   logic [31:0] ar_lat = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return 32'hA5A5_0000 + (a >> 2);
   endfunction

   // Slave: AR
   initial begin
      arready = 1'b0;
      forever begin
         wait_cyc(1);
         if (arvalid === 1'b1) begin
            wait_cyc(ar_dly);
            if (arvalid === 1'b1) begin
               arready = 1'b1;
               ar_lat  = araddr;
               wait_cyc(1);
               arready = 1'b0;
            end
         end
      end
   end

   // Slave: R
   initial begin
      rvalid = 1'b0;
      rdata  = '0;
      forever begin
         wait_cyc(1);
         if (rready === 1'b1) begin
            wait_cyc(r_dly);
            if (rready === 1'b1) begin
               rvalid = 1'b1;
               rdata  = mem_rd(ar_lat);
               wait_cyc(1);
               rvalid = 1'b0;
               rdata  = '0;
            end
         end
      end
   end

   // Slave: AW
   initial begin
      awready = 1'b0;
      forever begin
         wait_cyc(1);
         if (awvalid === 1'b1) begin
            wait_cyc(aw_dly);
            if (awvalid === 1'b1) begin
               awready = 1'b1;
               wait_cyc(1);
               awready = 1'b0;
            end
         end
      end
   end

   // Slave: W, optionally counted from the AW handshake
   initial begin
      wready = 1'b0;
      forever begin
         wait_cyc(1);
         if (wvalid === 1'b1) begin
            if (w_after_aw)
               for (int k = 0; k < 100 && awvalid === 1'b1; k++) wait_cyc(1);
            wait_cyc(w_dly);
            if (wvalid === 1'b1) begin
               wready = 1'b1;
               wait_cyc(1);
               wready = 1'b0;
            end
         end
      end
   end

   // Slave: B
   initial begin
      bvalid = 1'b0;
      forever begin
         wait_cyc(1);
         if (bready === 1'b1) begin
            wait_cyc(b_dly);
            if (bready === 1'b1) begin
               bvalid = 1'b1;
               wait_cyc(1);
               bvalid = 1'b0;
            end
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_done, p_rst;
      logic [31:0] p_ara, p_awa, p_wd;
      done_t       d;
      p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_done = 0; p_rst = 1;
      p_ara = '0; p_awa = '0; p_wd = '0;
      forever begin
         @(negedge clk);
         if (!rst && !p_rst) begin
            if (p_arv && !p_arr) begin
               chk("ar_hold", arvalid, 1);
               if (arvalid) chk("ar_stable", araddr, p_ara);
            end
            if (p_arv && p_arr) chk("ar_drop", arvalid, 0);
            if (p_awv && !p_awr) begin
               chk("aw_hold", awvalid, 1);
               if (awvalid) chk("aw_stable", awaddr, p_awa);
            end
            if (p_awv && p_awr) chk("aw_drop", awvalid, 0);
            if (p_wv && !p_wr) begin
               chk("w_hold", wvalid, 1);
               if (wvalid) chk("w_stable", wdata, p_wd);
            end
            if (p_wv && p_wr) chk("w_drop", wvalid, 0);
            if (arvalid && arready) begin
               if (exp_ar.size() == 0) chk("ar_unexpected", araddr, 32'hDEAD_BEEF);
               else chk("araddr", araddr, exp_ar.pop_front());
            end
            if (awvalid && awready) begin
               if (exp_aw.size() == 0) chk("aw_unexpected", awaddr, 32'hDEAD_BEEF);
               else chk("awaddr", awaddr, exp_aw.pop_front());
            end
            if (wvalid && wready) begin
               chk("wstrb", 32'(wstrb), 32'hF);
               if (exp_w.size() == 0) chk("w_unexpected", wdata, 32'hDEAD_BEEF);
               else chk("wdata", wdata, exp_w.pop_front());
            end
            if (done) begin
               done_cnt++;
               chk("done_width", 32'(p_done), 0);
               if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
               else begin
                  d = exp_done.pop_front();
                  chk("words_done", 32'(words_done), d.wd);
                  chk("checksum", checksum, d.cs);
               end
            end
         end
         p_arv = arvalid; p_arr = arready; p_ara = araddr;
         p_awv = awvalid; p_awr = awready; p_awa = awaddr;
         p_wv = wvalid; p_wr = wready; p_wd = wdata;
         p_done = done; p_rst = rst;
      end
   end

   task automatic do_start(input logic [31:0] s, input logic [31:0] dd, input logic [15:0] l);
      src_addr = s; dst_addr = dd; len_words = l; start = 1'b1;
      wait_cyc(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input int prev);
      int n = 0;
      while (done_cnt == prev && n < 3000) begin
         wait_cyc(1);
         n++;
      end
      chk("done_seen", 32'(done_cnt != prev), 1);
   endtask

   task automatic check_all_zero();
      chk("rst_busy", 32'(busy), 0);      chk("rst_done", 32'(done), 0);
      chk("rst_words", 32'(words_done), 0); chk("rst_cksum", checksum, 0);
      chk("rst_arvalid", 32'(arvalid), 0); chk("rst_araddr", araddr, 0);
      chk("rst_rready", 32'(rready), 0);   chk("rst_awvalid", 32'(awvalid), 0);
      chk("rst_awaddr", awaddr, 0);        chk("rst_wvalid", 32'(wvalid), 0);
      chk("rst_wdata", wdata, 0);          chk("rst_wstrb", 32'(wstrb), 0);
      chk("rst_bready", 32'(bready), 0);
   endtask

   initial begin
      int prev;
      int n;
      rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
      wait_cyc(3);
      check_all_zero();
      rst = 1'b0;
      wait_cyc(2);

      // Basic 3-word copy, zero-delay slave
      exp_ar.push_back(32'h10);  exp_ar.push_back(32'h14);  exp_ar.push_back(32'h18);
      exp_aw.push_back(32'h100); exp_aw.push_back(32'h104); exp_aw.push_back(32'h108);
      exp_w.push_back(32'hA5A5_0004); exp_w.push_back(32'hA5A5_0005); exp_w.push_back(32'hA5A5_0006);
      exp_done.push_back('{32'd3, 32'hA5A5_0007});
      prev = done_cnt;
      do_start(32'h10, 32'h100, 16'd3);
      chk("busy_running", 32'(busy), 1);
      wait_done(prev);
      wait_cyc(5);
      chk("one_done_basic", done_cnt, prev + 1);
      chk("idle_busy", 32'(busy), 0);
      chk("hold_words", 32'(words_done), 3);
      chk("hold_cksum", checksum, 32'hA5A5_0007);

      // Zero length: done on the cycle after start is taken, no bus traffic
      exp_done.push_back('{32'd0, 32'h0});
      prev = done_cnt;
      do_start(32'h20, 32'h200, 16'd0);
      chk("zero_done_lat", 32'(done), 1);
      wait_cyc(1);
      chk("zero_done_end", 32'(done), 0);
      chk("zero_busy_end", 32'(busy), 0);
      chk("zero_one_done", done_cnt, prev + 1);
      wait_cyc(3);

      // Address wrap; dst low bits are masked
      exp_ar.push_back(32'hFFFF_FFFC); exp_ar.push_back(32'h0000_0000);
      exp_aw.push_back(32'hFFFF_FFFC); exp_aw.push_back(32'h0000_0000);
      exp_w.push_back(32'hE5A4_FFFF);  exp_w.push_back(32'hA5A5_0000);
      exp_done.push_back('{32'd2, 32'h4001_FFFF});
      prev = done_cnt;
      do_start(32'hFFFF_FFFC, 32'hFFFF_FFFF, 16'd2);
      wait_done(prev);
      wait_cyc(3);

      // Slow slave, W counted from AW
      ar_dly = 3; r_dly = 1; aw_dly = 0; w_dly = 5; b_dly = 2; w_after_aw = 1'b1;
      exp_ar.push_back(32'h200); exp_ar.push_back(32'h204);
      exp_aw.push_back(32'h300); exp_aw.push_back(32'h304);
      exp_w.push_back(32'hA5A5_0080); exp_w.push_back(32'hA5A5_0081);
      exp_done.push_back('{32'd2, 32'h0000_0001});
      prev = done_cnt;
      do_start(32'h200, 32'h300, 16'd2);
      wait_done(prev);
      wait_cyc(3);

      // W accepted before AW
      ar_dly = 0; r_dly = 0; aw_dly = 4; w_dly = 0; b_dly = 0; w_after_aw = 1'b0;
      exp_ar.push_back(32'h400); exp_aw.push_back(32'h500);
      exp_w.push_back(32'hA5A5_0100);
      exp_done.push_back('{32'd1, 32'hA5A5_0100});
      prev = done_cnt;
      do_start(32'h400, 32'h500, 16'd1);
      wait_done(prev);
      wait_cyc(3);
      aw_dly = 0; w_after_aw = 1'b1;

      // start while busy is ignored
      exp_ar.push_back(32'h40);  exp_ar.push_back(32'h44);
      exp_aw.push_back(32'h600); exp_aw.push_back(32'h604);
      exp_w.push_back(32'hA5A5_0010); exp_w.push_back(32'hA5A5_0011);
      exp_done.push_back('{32'd2, 32'h0000_0001});
      prev = done_cnt;
      do_start(32'h40, 32'h600, 16'd2);
      for (int i = 0; i < 6; i++) begin
         wait_cyc(1);
         if (busy) do_start(32'h800, 32'h900, 16'd5);
      end
      wait_done(prev);
      wait_cyc(10);
      chk("busy_start_one_done", done_cnt, prev + 1);

      // Reset during WR of word 2, then a fresh single-word copy
      w_dly = 3;
      exp_ar.push_back(32'h1000); exp_ar.push_back(32'h1004);
      exp_aw.push_back(32'h2000); exp_aw.push_back(32'h2004);
      exp_w.push_back(32'hA5A5_0400);
      prev = done_cnt;
      do_start(32'h1000, 32'h2000, 16'd4);
      n = 0;
      while (!(wvalid && words_done == 16'd1) && n < 500) begin
         wait_cyc(1);
         n++;
      end
      chk("reach_wr2", 32'(wvalid && words_done == 16'd1), 1);
      wait_cyc(1);
      rst = 1'b1;
      wait_cyc(1);
      check_all_zero();
      rst = 1'b0;
      chk("rst_no_done", done_cnt, prev);
      wait_cyc(2);
      w_dly = 0;
      exp_ar.push_back(32'h1000); exp_aw.push_back(32'h3000);
      exp_w.push_back(32'hA5A5_0400);
      exp_done.push_back('{32'd1, 32'hA5A5_0400});
      do_start(32'h1000, 32'h3000, 16'd1);
      wait_done(prev);
      wait_cyc(5);
      chk("post_rst_words", 32'(words_done), 1);

      chk("ar_q_empty", exp_ar.size(), 0);
      chk("aw_q_empty", exp_aw.size(), 0);
      chk("w_q_empty", exp_w.size(), 0);
      chk("done_q_empty", exp_done.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
